// File: rtl/button_poller.sv
// rtl/button_poller.sv - Avalon-MM poller and debouncer for a 4-bit push-button PIO
//
// Reads the button PIO data register (address 0) once every POLL_CYCLES
// clocks and debounces each bit over DEBOUNCE_SAMPLES consecutive samples.
// The result is published as stable levels plus one-cycle press/release pulses.
//
// Parameters:
//   POLL_CYCLES      clocks from one poll start to the next (>= READ_LATENCY+3)
//   READ_LATENCY     clocks from read acceptance to valid avm_readdata
//   DEBOUNCE_SAMPLES consecutive differing samples needed to flip a stable bit
//   ACTIVE_LOW       1: raw 0 means pressed, 0: raw 1 means pressed
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   avm_address      Avalon address, always 2'b00
//   avm_read         Avalon read strobe
//   avm_waitrequest  slave stall
//   avm_readdata     slave read data, bits [3:0] used
//   buttons_stable   debounced levels, 1 = pressed
//   press_pulse      one-cycle pulse on a stable 0->1 transition
//   release_pulse    one-cycle pulse on a stable 1->0 transition
//
// Optional macro BUTTON_POLLER_IRQ_EN adds:
//   event_ack        clears all event flags
//   event_flags      sticky per-bit press flags
//   irq              registered OR of event_flags

module button_poller #(
  parameter int POLL_CYCLES      = 50000,
  parameter int READ_LATENCY     = 1,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter bit ACTIVE_LOW       = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [3:0]  buttons_stable,
  output logic [3:0]  press_pulse,
  output logic [3:0]  release_pulse
`ifdef BUTTON_POLLER_IRQ_EN
  ,
  input  logic        event_ack,
  output logic [3:0]  event_flags,
  output logic        irq
`endif
);

  localparam int IW = $clog2(POLL_CYCLES + 1);
  localparam int LW = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
  localparam int DW = $clog2(DEBOUNCE_SAMPLES + 1);

  localparam logic [IW-1:0] INTERVAL_RELOAD = IW'(POLL_CYCLES - 1);
  localparam logic [LW-1:0] LATENCY_LOAD    = LW'(READ_LATENCY);
  localparam logic [DW-1:0] DEBOUNCE_LAST   = DW'(DEBOUNCE_SAMPLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SAMPLE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [IW-1:0]   interval_cnt;
  logic [LW-1:0]   latency_cnt;
  logic [DW-1:0]   deb_cnt [4];
  logic [3:0]      sample_p;
  logic            unused_readdata;

  assign avm_address     = 2'b00;
  assign sample_p        = ACTIVE_LOW ? ~avm_readdata[3:0] : avm_readdata[3:0];
  assign unused_readdata = ^avm_readdata[31:4];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    avm_read   = 1'b0;
    case (state)
      S_IDLE: begin
        if (interval_cnt == '0) begin
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        avm_read = 1'b1;
        if (!avm_waitrequest) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        // Leave on the cycle the counter reaches 0 (a zero load leaves at once).
        if (latency_cnt <= LW'(1)) begin
          state_next = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // The interval counter free-runs in every state so poll starts stay on a
  // fixed grid; an expiry outside IDLE is simply lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      interval_cnt <= INTERVAL_RELOAD;
    end else if (interval_cnt == '0) begin
      interval_cnt <= INTERVAL_RELOAD;
    end else begin
      interval_cnt <= interval_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      latency_cnt <= '0;
    end else if (state == S_REQ && !avm_waitrequest) begin
      latency_cnt <= LATENCY_LOAD;
    end else if (state == S_WAIT && latency_cnt != '0) begin
      latency_cnt <= latency_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buttons_stable <= 4'b0000;
      press_pulse    <= 4'b0000;
      release_pulse  <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      press_pulse   <= 4'b0000;
      release_pulse <= 4'b0000;
      if (state == S_SAMPLE) begin
        for (int i = 0; i < 4; i++) begin
          if (sample_p[i] == buttons_stable[i]) begin
            // Any agreeing sample, including a single bounce, restarts the count.
            deb_cnt[i] <= '0;
          end else if (deb_cnt[i] == DEBOUNCE_LAST) begin
            deb_cnt[i]        <= '0;
            buttons_stable[i] <= sample_p[i];
            press_pulse[i]    <= sample_p[i];
            release_pulse[i]  <= ~sample_p[i];
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

`ifdef BUTTON_POLLER_IRQ_EN
  // A press arriving in the same cycle as an ack survives the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      event_flags <= 4'b0000;
      irq         <= 1'b0;
    end else begin
      event_flags <= (event_flags & ~{4{event_ack}}) | press_pulse;
      irq         <= |event_flags;
    end
  end
`endif

endmodule

// File: tb/tb_button_poller.sv
// tb/tb_button_poller.sv - directed scoreboard bench for button_poller

module tb_button_poller;

  localparam int POLL = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = 32'h0000_000F;
  logic [3:0]  buttons_stable;
  logic [3:0]  press_pulse;
  logic [3:0]  release_pulse;
`ifdef BUTTON_POLLER_IRQ_EN
  logic        event_ack = 1'b0;
  logic [3:0]  event_flags;
  logic        irq;
  logic [3:0]  exp_flags = 4'b0000;
`endif

  button_poller #(
    .POLL_CYCLES(POLL),
    .READ_LATENCY(1),
    .DEBOUNCE_SAMPLES(4),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata),
    .buttons_stable(buttons_stable),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse)
`ifdef BUTTON_POLLER_IRQ_EN
    ,
    .event_ack(event_ack),
    .event_flags(event_flags),
    .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          last_req = 0;
  logic [11:0] sb_q[$];
  logic [3:0]  m_stable = 4'b0000;
  int          m_cnt[4] = '{0, 0, 0, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent debounce model: pushes {stable, press, release} per sample.
  task automatic model_sample(input logic [3:0] raw);
    logic [3:0] p;
    logic [3:0] pr;
    logic [3:0] rl;
    p  = ~raw;
    pr = 4'b0000;
    rl = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (p[i] == m_stable[i]) begin
        m_cnt[i] = 0;
      end else begin
        m_cnt[i]++;
        if (m_cnt[i] == 4) begin
          m_cnt[i]    = 0;
          m_stable[i] = p[i];
          if (p[i]) pr[i] = 1'b1;
          else      rl[i] = 1'b1;
        end
      end
    end
    sb_q.push_back({m_stable, pr, rl});
  endtask

  task automatic poll(input logic [3:0] raw, input int gap, input int stall, input bit rst_in_wait);
    int          n;
    logic [11:0] e;
    avm_readdata = {28'hFFF_FFFF, raw};
    if (stall > 0) avm_waitrequest = 1'b1;
    n = 0;
    @(negedge clk);
    while (!avm_read && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("read_seen", avm_read, 1);
    if (!avm_read) return;
    check("poll_gap", cyc - last_req, gap);
    last_req = cyc;
    check("avm_address", avm_address, 0);
`ifdef BUTTON_POLLER_IRQ_EN
    check("irq", irq, |exp_flags);
`endif
    if (!rst_in_wait) model_sample(raw);
    if (stall > 0) begin
      for (int k = 1; k < stall; k++) begin
        @(negedge clk);
        check("stall_hold", avm_read, 1);
      end
      avm_waitrequest = 1'b0;
    end
    @(negedge clk);
    check("read_dropped", avm_read, 0);
    if (rst_in_wait) begin
      reset_n = 1'b0;
      #1;
      check("rst_stable", buttons_stable, 0);
      check("rst_pulses", {press_pulse, release_pulse}, 0);
      check("rst_read", avm_read, 0);
      repeat (3) @(negedge clk);
      check("rst_hold", {avm_read, buttons_stable}, 0);
      reset_n  = 1'b1;
      last_req = cyc;
      m_stable = 4'b0000;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
`ifdef BUTTON_POLLER_IRQ_EN
      exp_flags = 4'b0000;
`endif
      return;
    end
    @(negedge clk);
    check("pre_pulse", {press_pulse, release_pulse}, 0);
    @(negedge clk);
    e = sb_q.pop_front();
    check("stable", buttons_stable, e[11:8]);
    check("press", press_pulse, e[7:4]);
    check("release", release_pulse, e[3:0]);
`ifdef BUTTON_POLLER_IRQ_EN
    exp_flags = exp_flags | e[7:4];
`endif
    @(negedge clk);
    check("pulse_one_cycle", {press_pulse, release_pulse}, 0);
`ifdef BUTTON_POLLER_IRQ_EN
    check("event_flags", event_flags, exp_flags);
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_stable", buttons_stable, 0);
    check("reset_pulses", {press_pulse, release_pulse}, 0);
    check("reset_read", avm_read, 0);
    check("reset_address", avm_address, 0);
    reset_n  = 1'b1;
    last_req = cyc;

    // Nothing pressed: reads on an 8-cycle grid, no changes.
    repeat (3) poll(4'hF, POLL, 0, 1'b0);

    // Bit0 press held four samples, then released four samples.
    repeat (4) poll(4'hE, POLL, 0, 1'b0);
    repeat (4) poll(4'hF, POLL, 0, 1'b0);

    // Bounce on bit2: raw 0,1,0,0,0,0.
    poll(4'hB, POLL, 0, 1'b0);
    poll(4'hF, POLL, 0, 1'b0);
    repeat (4) poll(4'hB, POLL, 0, 1'b0);

    // Twelve-cycle stall; the overlapping expiry is lost, grid preserved.
    poll(4'hB, POLL, 12, 1'b0);
    poll(4'hB, 2 * POLL, 0, 1'b0);

    // Bits 1 and 3 press while bit2 releases in the same sample.
    repeat (4) poll(4'h5, POLL, 0, 1'b0);

    // Reset during WAIT with 4'b1010 stable, then a fresh debounce.
    poll(4'h5, POLL, 0, 1'b1);
    repeat (4) poll(4'h5, POLL, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button_poller.md
Name: button_poller

Overview:
- Avalon-MM master that periodically reads the 4-bit push-button PIO slave (data register, address 0) and debounces each bit.
- Publishes stable button levels plus single-cycle press/release pulses to the alarm-clock control logic.
- Sits between the button PIO's s1 slave port and the alarm FSM, so the FSM never polls the bus itself.

Parameters:
POLL_CYCLES, 50000, clk cycles from one poll's start to the next (>= READ_LATENCY+3).
READ_LATENCY, 1, cycles from read acceptance to valid avm_readdata (PIO registers readdata).
DEBOUNCE_SAMPLES, 4, consecutive equal samples needed to change a stable bit (>= 1).
ACTIVE_LOW, 1, 1: a raw 0 means pressed; 0: a raw 1 means pressed.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
avm_address  out  2  Avalon address, constant 2'b00
avm_read  out  1  Avalon read strobe
avm_waitrequest  in  1  slave stall; tie 0 for the PIO
avm_readdata  in  32  slave read data; bits [3:0] used
buttons_stable  out  4  debounced levels, 1 = pressed
press_pulse  out  4  1-cycle pulse on a stable 0->1 transition
release_pulse  out  4  1-cycle pulse on a stable 1->0 transition

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, interval counter=POLL_CYCLES-1, debounce counters=0, buttons_stable=0, press/release pulses=0, avm_read=0. avm_address is always 0.
- FSM states:
  - IDLE: interval counter decrements each cycle. At 0, reload to POLL_CYCLES-1 and go to REQ.
  - REQ: avm_read=1. Hold while avm_waitrequest=1. In the first cycle with avm_waitrequest=0, the read is accepted; load the latency counter with READ_LATENCY and go to WAIT.
  - WAIT: latency counter decrements. On the cycle it reaches 0, go to SAMPLE.
  - SAMPLE: capture p = avm_readdata[3:0], inverted when ACTIVE_LOW=1. Update the debounce logic. Return to IDLE.
- The interval counter keeps running in REQ/WAIT/SAMPLE. A poll start is therefore every POLL_CYCLES cycles regardless of stalls.
- Interval expiry while not in IDLE is dropped; it is not queued. An overrun does not change the next period.
- Debounce, per bit i, in SAMPLE only:
  - If p[i]==buttons_stable[i]: cnt[i]=0.
  - Otherwise cnt[i]++. When cnt[i] reaches DEBOUNCE_SAMPLES, flip buttons_stable[i], clear cnt[i], and pulse press_pulse[i] (if the new level is 1) or release_pulse[i] (if 0).
  - Bits are independent. Multiple bits may flip in the same sample.
- Pulses are registered: exactly one cycle high, in the cycle after SAMPLE. They are 0 at all other times.
- Counters saturate-free. Widths are $clog2 of (parameter+1). No wrap is reachable.
- Reset mid-transaction: avm_read drops immediately (async). After release, the next read is at least POLL_CYCLES cycles away. A stale readdata is never sampled.
- A single bounce sample (p differs once, then matches) restarts the count from 0.

Optional Feature:
BUTTON_POLLER_IRQ_EN
- Defined:
  - Adds input event_ack (1 bit) and outputs event_flags (4 bits, reset 0) and irq (1 bit, reset 0).
  - event_flags[i] is set by press_pulse[i].
  - event_ack=1 clears all flags in that cycle. Set wins over clear when both happen in the same cycle.
  - irq is registered and equals |event_flags, one cycle later.
- Not defined: the ports and logic are absent; the rest of the behaviour is identical.

Test Plan:
- Idle, POLL_CYCLES=8, waitrequest=0, readdata=32'hF (nothing pressed) -> avm_read high 1 cycle every 8 cycles, first at cycle 8 after reset release; buttons_stable stays 0; no pulses.
- readdata[0]=0 held (ACTIVE_LOW, DEBOUNCE_SAMPLES=4) -> buttons_stable[0]=1 after 4th sample; press_pulse=4'b0001 for exactly 1 cycle; release to 1 for 4 samples -> release_pulse=4'b0001.
- Bounce pattern on bit2 across samples 0,1,0,0,0,0 (raw) -> stable[2] flips only after the 4th consecutive 0; a single pulse.
- avm_waitrequest held 1 for 12 cycles with POLL_CYCLES=8 -> avm_read stays high 12 cycles, the overlapping expiry is dropped, next poll starts on the original 8-cycle grid.
- reset_n pulsed low during WAIT with buttons 4'b1010 stable -> all outputs 0 immediately; re-debounce needs 4 fresh samples.
- BUTTON_POLLER_IRQ_EN, press bit3 -> event_flags=4'b1000, irq=1 next cycle; event_ack in the same cycle as a new press_pulse[1] -> flags=4'b0010.
